uart_rx_frame: RTL
==================

# uart_rx_frame

Parametrised UART receiver with configurable data width, optional parity, one or two stop bits, and framing/parity error reporting. It sits between the serial input pin and the operand-collecting interface block, replacing the fixed 8N1 receiver. It is driven by the shared baud-rate generator tick. It presents each received word with a one-cycle valid pulse plus error qualifiers.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9, LSB first.
- `OVERSAMPLE`, 16: `i_tick` pulses per bit time; even, ≥ 8.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `i_clock`  in  1  system clock.
- `i_reset`  in  1  reset, asynchronous, active-high.
- `i_tick`  in  1  one-clock pulse at OVERSAMPLE × baud.
- `i_rx`  in  1  serial line, idle high, asynchronous to `i_clock`.
- `o_data`  out  DATA_BITS  last received word; holds until the next frame completes.
- `o_valid`  out  1  one-clock pulse; `o_data` and the error flags are valid in that cycle.
- `o_parity_err`  out  1  parity mismatch on the last frame; always 0 when PARITY = 0.
- `o_frame_err`  out  1  a stop bit sampled low on the last frame.
- `o_busy`  out  1  high in every state except IDLE.

## Operation
- `i_rx` passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the synchronized value.
- State machine (states from shared package): IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: synced rx = 0 → START; clear the tick counter and bit counter.
  - START: on the tick where counter = OVERSAMPLE/2−1, sample the line.
    - Line = 0 → DATA, clear counter.
    - Line = 1 → false start, return to IDLE; no valid pulse, no flags.
  - DATA: on the tick where counter = OVERSAMPLE−1, sample the line and shift it in LSB first, then clear counter.
    - After DATA_BITS samples → PARITY if PARITY ≠ 0, else STOP.
  - PARITY: sample the line at the same point. Mismatch sets an internal parity flag.
    - Odd mode: mismatch when data plus parity bit has an even number of 1s.
    - Even mode: mismatch when it has an odd number of 1s.
  - STOP: sample STOP_BITS times at the same point; any low sample sets an internal frame flag.
    - After the last sample: load `o_data`, `o_parity_err` and `o_frame_err`, and pulse `o_valid`.
    - Next state is BREAK if the frame flag is set, else IDLE.
  - BREAK: wait for synced rx = 1 → IDLE. A line held low produces exactly one frame-error word, not repeated zero frames.
- Ticks outside the sample points only increment the counter. Clock cycles without `i_tick` change nothing except the synchronizer.
- Error flags are registered and hold their value until the next `o_valid`.

## Timing
- Reset values: `o_data` = 0, `o_valid` = 0, `o_parity_err` = 0, `o_frame_err` = 0, `o_busy` = 0, state IDLE, counters 0.
- Reset asserted mid-frame aborts immediately: no `o_valid`, partial data discarded.
- Start detection latency: 2 clocks (synchronizer) + 1 clock (state register).
- `o_valid` is asserted in the clock after the `i_tick` on which the last stop bit is sampled. This is mid-stop-bit, so back-to-back frames with no idle gap are received without loss.
- The tick counter is $clog2(OVERSAMPLE) bits wide; the bit counter is $clog2(DATA_BITS+1) bits wide.
- `i_tick` high in consecutive clocks is legal: one count per high cycle.

## Structure
- Shared package/header `uart_defs` holds:
  - parity mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - the state encoding (3 bits);
  - the default OVERSAMPLE.
- Natural sub-module: `sync_2ff`, a 2-flop synchronizer with reset value parameter 1. It is reusable for other asynchronous inputs.
- The remainder is a single FSM with counters and a shift register; expect ~180 lines.

## Test plan
- 8N1 (PARITY = 0, STOP_BITS = 1), frame 0x02 at tick-per-16-bit-time → `o_data` = 0x02, one `o_valid` pulse, both error flags 0, `o_busy` back to 0.
- PARITY = 2, frame 0x20:
  - parity bit 1 → `o_parity_err` = 0;
  - repeat with parity bit 0 → `o_data` = 0x20, `o_parity_err` = 1.
- Frame 0x55 with stop bit 0, then line held low 3 bit times → exactly one `o_valid` with `o_frame_err` = 1 and `o_data` = 0x55. Then restore the line high and send 0x04 → `o_data` = 0x04, `o_frame_err` = 0.
- Glitch: rx low for 4 ticks then high → no `o_valid`; `o_busy` pulses then returns to 0 before tick 8.
- Reset asserted during bit 3 of 0x06, released, then full frame 0x06 → no `o_valid` before the release, then `o_data` = 0x06 with no errors.
- Back-to-back 0x02, 0x04, 0x20 with no idle gap, STOP_BITS = 1 → three `o_valid` pulses, in order, no errors.

Source files
------------

// File: rtl/uart_defs_pkg.sv
// rtl/uart_defs_pkg.sv - shared UART constants and receiver state encoding
package uart_defs;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   localparam int DEFAULT_OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_d,
   output logic o_q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= i_d;
         sync_q <= meta_q;
      end
   end

   assign o_q = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - oversampling UART receiver with parity, 1/2 stop bits and error flags
module uart_rx_frame
   import uart_defs::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
   parameter int PARITY     = PAR_NONE,
   parameter int STOP_BITS  = 1
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic                 i_tick,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_busy
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] MID_START = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] MID_BIT   = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   rx_state_t            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 par_flag_q, par_flag_d;
   logic                 frame_flag_q, frame_flag_d;
   logic                 valid_q, valid_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 rx_s;
   logic                 frame_bad;
   logic                 par_odd_ones;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_d     (i_rx),
      .o_q     (rx_s)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      bit_d        = bit_q;
      shift_d      = shift_q;
      data_d       = data_q;
      par_flag_d   = par_flag_q;
      frame_flag_d = frame_flag_q;
      valid_d      = 1'b0;
      perr_d       = perr_q;
      ferr_d       = ferr_q;
      frame_bad    = frame_flag_q | ~rx_s;
      par_odd_ones = (^shift_q) ^ rx_s;

      case (state_q)
         ST_IDLE: begin
            if (!rx_s) begin
               state_d      = ST_START;
               cnt_d        = '0;
               bit_d        = '0;
               par_flag_d   = 1'b0;
               frame_flag_d = 1'b0;
            end
         end
         ST_START: begin
            if (i_tick) begin
               if (cnt_q == MID_START) begin
                  cnt_d   = '0;
                  state_d = rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ST_DATA: begin
            if (i_tick) begin
               if (cnt_q == MID_BIT) begin
                  cnt_d   = '0;
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  if (bit_q == LAST_DATA) begin
                     bit_d   = '0;
                     state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_d = bit_q + BW'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ST_PARITY: begin
            if (i_tick) begin
               if (cnt_q == MID_BIT) begin
                  cnt_d      = '0;
                  par_flag_d = (PARITY == PAR_ODD) ? ~par_odd_ones : par_odd_ones;
                  state_d    = ST_STOP;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ST_STOP: begin
            if (i_tick) begin
               if (cnt_q == MID_BIT) begin
                  cnt_d        = '0;
                  frame_flag_d = frame_bad;
                  if (bit_q == LAST_STOP) begin
                     // Publish mid-stop-bit so a following start edge is not missed.
                     bit_d   = '0;
                     data_d  = shift_q;
                     perr_d  = (PARITY != PAR_NONE) && par_flag_q;
                     ferr_d  = frame_bad;
                     valid_d = 1'b1;
                     state_d = frame_bad ? ST_BREAK : ST_IDLE;
                  end else begin
                     bit_d = bit_q + BW'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ST_BREAK: begin
            if (rx_s) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         par_flag_q   <= 1'b0;
         frame_flag_q <= 1'b0;
         valid_q      <= 1'b0;
         perr_q       <= 1'b0;
         ferr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         par_flag_q   <= par_flag_d;
         frame_flag_q <= frame_flag_d;
         valid_q      <= valid_d;
         perr_q       <= perr_d;
         ferr_q       <= ferr_d;
      end
   end

   assign o_data       = data_q;
   assign o_valid      = valid_q;
   assign o_parity_err = perr_q;
   assign o_frame_err  = ferr_q;
   assign o_busy       = (state_q != ST_IDLE);

endmodule
